// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end and its pipeline registers.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  // Redirect targets are word aligned; misaligned low bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with write-enable, flush and bubble insert; reused between stages.
module if_id_reg import fetch_pkg::*; #(
  parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic            flush_i,
  input  logic            bubble_i,
  input  fetch_pkt_t      pkt_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o
);

  // Flush beats everything; a bubble keeps the PC for debug visibility but is never valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_o    <= '0;
      instr_o <= NOP;
      valid_o <= 1'b0;
    end else if (flush_i) begin
      pc_o    <= '0;
      instr_o <= NOP;
      valid_o <= 1'b0;
    end else if (we_i && bubble_i) begin
      pc_o    <= pkt_i.pc;
      instr_o <= NOP;
      valid_o <= 1'b0;
    end else if (we_i) begin
      pc_o    <= pkt_i.pc;
      instr_o <= pkt_i.instr;
      valid_o <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem handshake, one-entry skid buffer and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module fetch_stage #(
  parameter logic [fetch_pkg::XLEN-1:0] RESET_PC  = fetch_pkg::RESET_PC_DEFAULT,
  parameter logic [fetch_pkg::XLEN-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      PCWrite,
  input  logic                      IF_ID_Write,
  input  logic                      Branch_Taken,
  input  logic [fetch_pkg::XLEN-1:0] Branch_Target,
  output logic                      imem_req,
  output logic [fetch_pkg::XLEN-1:0] imem_addr,
  input  logic                      imem_ready,
  input  logic [fetch_pkg::XLEN-1:0] imem_rdata,
  output logic [fetch_pkg::XLEN-1:0] IF_ID_PC,
  output logic [fetch_pkg::XLEN-1:0] IF_ID_Instruction,
`ifdef FETCH_PERF_CNT_EN
  output logic [fetch_pkg::XLEN-1:0] perf_stall_cycles,
  output logic [fetch_pkg::XLEN-1:0] perf_flushes,
`endif
  output logic                      IF_ID_Valid,
  output logic                      Fetch_Busy
);
  import fetch_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  fetch_pkt_t      skid_q, skid_d;
  logic            req_q, req_d;

  logic            fire, pending;
  logic            ifid_we, ifid_flush, ifid_bubble;
  fetch_pkt_t      ifid_pkt;
  logic [XLEN-1:0] redirect_pc;

  assign fire        = req_q && imem_ready;
  assign pending     = req_q && !imem_ready;
  assign redirect_pc = align_pc(Branch_Target);

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign Fetch_Busy = req_q && !imem_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    skid_d      = skid_q;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    ifid_bubble = 1'b0;
    ifid_pkt    = '{pc: pc_q, instr: imem_rdata};

    if (Branch_Taken) begin
      ifid_flush = 1'b1;
      skid_d     = '0;
      // An outstanding request must finish on its old address before the target goes out.
      if (pending) begin
        tgt_d   = redirect_pc;
        state_d = DROP;
      end else begin
        pc_d    = redirect_pc;
        state_d = FETCH;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (fire) begin
            if (IF_ID_Write) begin
              ifid_we = 1'b1;
              if (PCWrite) pc_d = pc_q + XLEN'(4);
            end else begin
              skid_d  = ifid_pkt;
              state_d = HOLD;
            end
          end else if (IF_ID_Write) begin
            ifid_we     = 1'b1;
            ifid_bubble = 1'b1;
          end
        end
        HOLD: begin
          if (IF_ID_Write) begin
            ifid_we  = 1'b1;
            ifid_pkt = skid_q;
            if (PCWrite) pc_d = pc_q + XLEN'(4);
            state_d  = FETCH;
          end
        end
        DROP: begin
          if (imem_ready) begin
            pc_d    = tgt_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end

    req_d = (state_d != HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      skid_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      skid_q  <= skid_d;
      req_q   <= req_d;
    end
  end

  if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .we_i     (ifid_we),
    .flush_i  (ifid_flush),
    .bubble_i (ifid_bubble),
    .pkt_i    (ifid_pkt),
    .pc_o     (IF_ID_PC),
    .instr_o  (IF_ID_Instruction),
    .valid_o  (IF_ID_Valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!IF_ID_Write && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + XLEN'(1);
      if (Branch_Taken && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + XLEN'(1);
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flushes      = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stalls, wait states, redirects, reset and PC wrap.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite, IF_ID_Write, Branch_Taken;
  logic [31:0] Branch_Target;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] IF_ID_PC, IF_ID_Instruction;
  logic        IF_ID_Valid, Fetch_Busy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flushes;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Memory returns a word tagged with its own address.
  assign imem_rdata = {12'hABC, imem_addr[19:0]};

  fetch_stage dut (
    .clk               (clk),
    .rst               (rst),
    .PCWrite           (PCWrite),
    .IF_ID_Write       (IF_ID_Write),
    .Branch_Taken      (Branch_Taken),
    .Branch_Target     (Branch_Target),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ready        (imem_ready),
    .imem_rdata        (imem_rdata),
    .IF_ID_PC          (IF_ID_PC),
    .IF_ID_Instruction (IF_ID_Instruction),
`ifdef FETCH_PERF_CNT_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes),
`endif
    .IF_ID_Valid       (IF_ID_Valid),
    .Fetch_Busy        (Fetch_Busy)
  );

  // {req, busy, addr, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid}
  logic [98:0] obs;
  assign obs = {imem_req, Fetch_Busy, imem_addr, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [98:0] exp;
    repeat (2) @(posedge clk);
    #1;
    exp = {1'b0, 1'b0, 32'h0, 32'h0, NOP, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_state: got %h want %h", obs, exp); end
    rst = 1'b0;
    step();
    exp = {1'b1, 1'b0, 32'h0, 32'h0, NOP, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL first_req: got %h want %h", obs, exp); end
    step();
    exp = {1'b1, 1'b0, 32'h4, 32'h0, 32'hABC0_0000, 1'b1};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL stream_4: got %h want %h", obs, exp); end
    step();
    exp = {1'b1, 1'b0, 32'h8, 32'h4, 32'hABC0_0004, 1'b1};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL stream_8: got %h want %h", obs, exp); end
  endtask

  task automatic test_stall();
    logic [98:0] exp;
    IF_ID_Write = 1'b0; PCWrite = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      exp = {1'b0, 1'b0, 32'h8, 32'h4, 32'hABC0_0004, 1'b1};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL stall_hold_%0d: got %h want %h", i, obs, exp); end
    end
    IF_ID_Write = 1'b1; PCWrite = 1'b1;
    step();
    exp = {1'b1, 1'b0, 32'hC, 32'h8, 32'hABC0_0008, 1'b1};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL skid_release: got %h want %h", obs, exp); end
    step();
    exp = {1'b1, 1'b0, 32'h10, 32'hC, 32'hABC0_000C, 1'b1};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL after_skid: got %h want %h", obs, exp); end
  endtask

  task automatic test_wait_states();
    logic [98:0] exp;
    imem_ready = 1'b0;
    #1;
    exp = {1'b1, 1'b1, 32'h10, 32'hC, 32'hABC0_000C, 1'b1};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL busy_comb: got %h want %h", obs, exp); end
    for (int i = 0; i < 3; i++) begin
      step();
      exp = {1'b1, 1'b1, 32'h10, 32'h10, NOP, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL wait_bubble_%0d: got %h want %h", i, obs, exp); end
    end
    imem_ready = 1'b1;
    step();
    exp = {1'b1, 1'b0, 32'h14, 32'h10, 32'hABC0_0010, 1'b1};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL wait_done: got %h want %h", obs, exp); end
  endtask

  task automatic test_branch_drop();
    logic [98:0] exp;
    repeat (3) step();
    exp = {1'b1, 1'b0, 32'h20, 32'h1C, 32'hABC0_001C, 1'b1};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reach_20: got %h want %h", obs, exp); end
    imem_ready = 1'b0; Branch_Taken = 1'b1; Branch_Target = 32'h0000_0103;
    step();
    Branch_Taken = 1'b0;
    exp = {1'b1, 1'b1, 32'h20, 32'h0, NOP, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL drop_enter: got %h want %h", obs, exp); end
    step();
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL drop_hold: got %h want %h", obs, exp); end
    imem_ready = 1'b1;
    step();
    exp = {1'b1, 1'b0, 32'h100, 32'h0, NOP, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL drop_exit: got %h want %h", obs, exp); end
    step();
    exp = {1'b1, 1'b0, 32'h104, 32'h100, 32'hABC0_0100, 1'b1};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL target_fetch: got %h want %h", obs, exp); end
  endtask

  task automatic test_branch_hold();
    logic [98:0] exp;
    IF_ID_Write = 1'b0; PCWrite = 1'b0;
    step();
    exp = {1'b0, 1'b0, 32'h104, 32'h100, 32'hABC0_0100, 1'b1};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL hold_enter: got %h want %h", obs, exp); end
    Branch_Taken = 1'b1; Branch_Target = 32'h0000_0200;
    step();
    Branch_Taken = 1'b0; IF_ID_Write = 1'b1; PCWrite = 1'b1;
    exp = {1'b1, 1'b0, 32'h200, 32'h0, NOP, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL hold_redirect: got %h want %h", obs, exp); end
    step();
    exp = {1'b1, 1'b0, 32'h204, 32'h200, 32'hABC0_0200, 1'b1};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL skid_cleared: got %h want %h", obs, exp); end
  endtask

  task automatic test_drop_retarget();
    logic [98:0] exp;
    imem_ready = 1'b0; Branch_Taken = 1'b1; Branch_Target = 32'h0000_0300;
    step();
    exp = {1'b1, 1'b1, 32'h204, 32'h0, NOP, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL retarget_drop: got %h want %h", obs, exp); end
    Branch_Target = 32'h0000_0406;
    step();
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL retarget_again: got %h want %h", obs, exp); end
    Branch_Taken = 1'b0; imem_ready = 1'b1;
    step();
    exp = {1'b1, 1'b0, 32'h404, 32'h0, NOP, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL retarget_exit: got %h want %h", obs, exp); end
    step();
    exp = {1'b1, 1'b0, 32'h408, 32'h404, 32'hABC0_0404, 1'b1};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL retarget_fetch: got %h want %h", obs, exp); end
  endtask

  task automatic test_reset_mid_drop();
    logic [98:0] exp;
    imem_ready = 1'b0; Branch_Taken = 1'b1; Branch_Target = 32'h0000_0500;
    step();
    Branch_Taken = 1'b0;
    exp = {1'b1, 1'b1, 32'h408, 32'h0, NOP, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL pre_reset_drop: got %h want %h", obs, exp); end
    #2;
    rst = 1'b1;
    #1;
    exp = {1'b0, 1'b0, 32'h0, 32'h0, NOP, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL async_reset: got %h want %h", obs, exp); end
    imem_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    exp = {1'b1, 1'b0, 32'h0, 32'h0, NOP, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL post_reset_req: got %h want %h", obs, exp); end
    step();
    exp = {1'b1, 1'b0, 32'h4, 32'h0, 32'hABC0_0000, 1'b1};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL post_reset_fetch: got %h want %h", obs, exp); end
  endtask

  task automatic test_pc_wrap();
    logic [98:0] exp;
    Branch_Taken = 1'b1; Branch_Target = 32'hFFFF_FFFF;
    step();
    Branch_Taken = 1'b0;
    exp = {1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, NOP, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL wrap_redirect: got %h want %h", obs, exp); end
    step();
    exp = {1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'hABCF_FFFC, 1'b1};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL wrap_zero: got %h want %h", obs, exp); end
    step();
    exp = {1'b1, 1'b0, 32'h4, 32'h0, 32'hABC0_0000, 1'b1};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL wrap_next: got %h want %h", obs, exp); end
  endtask

  initial begin
    rst           = 1'b1;
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    Branch_Taken  = 1'b0;
    Branch_Target = 32'h0;
    imem_ready    = 1'b1;

    test_reset();
    test_stall();
    test_wait_states();
    test_branch_drop();
    test_branch_hold();
    test_drop_retarget();
    test_reset_mid_drop();
    test_pc_wrap();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the 5-stage RISC-V pipeline, downstream consumer of the load-use hazard unit.
- Owns the PC, the handshake to instruction memory, a one-entry skid buffer and the IF/ID pipeline register.
- Honours PCWrite/IF_ID_Write stalls and EX-stage branch redirects, inserting NOP bubbles as required.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, encoding of addi x0,x0,0 used for bubbles and flushes.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- PCWrite  in  1  from hazard unit; 0 = freeze PC
- IF_ID_Write  in  1  from hazard unit; 0 = hold IF/ID register
- Branch_Taken  in  1  EX-stage redirect request
- Branch_Target  in  32  redirect PC
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address
- imem_ready  in  1  memory accepts; imem_rdata valid in the same cycle
- imem_rdata  in  32  instruction word
- IF_ID_PC  out  32  PC of the instruction in IF/ID
- IF_ID_Instruction  out  32  instruction in IF/ID
- IF_ID_Valid  out  1  1 = real instruction, 0 = bubble
- Fetch_Busy  out  1  imem_req && !imem_ready

Behaviour:
- Reset (async, immediate):
  - PC = RESET_PC; IF_ID_PC = 0; IF_ID_Instruction = NOP_INSTR; IF_ID_Valid = 0.
  - imem_req = 0; skid buffer empty; state = FETCH.
  - First request issues in the first cycle after rst deasserts.
- Transaction: completes on a cycle with imem_req && imem_ready. imem_addr must stay stable while imem_req && !imem_ready. imem_addr = PC in FETCH.
- States:
  - FETCH: imem_req = 1.
  - HOLD: imem_req = 0; skid buffer full.
  - DROP: imem_req = 1 on the stale address; the response will be discarded.
- FETCH transitions:
  - Completion with IF_ID_Write = 1: IF/ID ← {PC, rdata, 1}. PC ← PC+4 if PCWrite. Stay in FETCH.
  - Completion with IF_ID_Write = 0: skid ← {PC, rdata}; PC unchanged; go to HOLD.
  - No completion with IF_ID_Write = 1: IF/ID ← {PC, NOP_INSTR, 0} (bubble).
  - No completion with IF_ID_Write = 0: IF/ID holds.
- HOLD: when IF_ID_Write = 1, IF/ID ← {skid, 1}, PC ← PC+4 if PCWrite, go to FETCH. Otherwise hold.
- Redirect (Branch_Taken) has priority over stalls and completion in all states:
  - IF/ID ← {0, NOP_INSTR, 0}; skid cleared.
  - PC ← {Branch_Target[31:2], 2'b00} (misaligned low bits forced to 0).
  - If in FETCH with a pending request (imem_req && !imem_ready): latch the target, go to DROP.
  - Otherwise go to FETCH; the new target is fetched next cycle.
- DROP: hold the old address until imem_ready, discard the data, then load PC from the latched target and go to FETCH. A further Branch_Taken in DROP overwrites the latched target.
- PC arithmetic is mod 2^32: 0xFFFF_FFFC + 4 = 0x0000_0000.
- PCWrite = 1 with IF_ID_Write = 0 never occurs from the hazard unit; if it does, treat it as a full stall (PC frozen).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds output ports perf_stall_cycles[31:0] (cycles with IF_ID_Write = 0) and perf_flushes[31:0] (cycles with Branch_Taken = 1).
- Both counters reset to 0 and saturate at 0xFFFF_FFFF.
- When undefined, the ports and logic are absent and the remaining behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INSTR constant.
  - fetch_state_t enum {FETCH, HOLD, DROP}.
  - Default RESET_PC.
- One sub-module, if_id_reg: IF/ID register with write-enable, flush and bubble insert, reused by the ID/EX equivalent.
- PC, skid buffer and FSM stay in fetch_stage.

Test Plan:
- Reset release, imem_ready tied 1, no stalls -> imem_addr 0x0, 0x4, 0x8; IF_ID_PC lags by one cycle; IF_ID_Valid = 1 from the second cycle.
- IF_ID_Write = PCWrite = 0 for 2 cycles while fetching 0x8 -> IF/ID holds 0x4; the 0x8 word is held in skid (HOLD, imem_req = 0); on release, IF/ID gets 0x8, then fetch of 0xC.
- imem_ready low 3 cycles at 0x10 -> three bubbles (Valid = 0, NOP_INSTR); Fetch_Busy = 1 throughout; imem_addr stable at 0x10.
- Branch_Taken with target 0x103 while the 0x20 request is pending -> DROP; 0x20 data discarded; next request address 0x100; IF/ID flushed.
- Branch_Taken in the same cycle as IF_ID_Write = 0 in HOLD -> skid cleared; IF_ID_Valid = 0; PC = target.
- rst asserted mid-DROP -> all outputs immediately at reset values; first post-reset request to RESET_PC.
